// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer family: default geometry and a constant-safe clog2.
package buffer_pkg;

    localparam int unsigned BufDefaultWidth = 8;
    localparam int unsigned BufDefaultDepth = 4;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
module buffer_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    // Contents are deliberately not reset; occupancy is tracked by the pointers.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides and occupancy flags.
module fifo_buffer
    import buffer_pkg::*;
#(
    parameter int unsigned WIDTH    = BufDefaultWidth,
    parameter int unsigned DEPTH    = BufDefaultDepth,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       I_DATA,
    input  logic                   I_VALID,
    output logic                   I_READY,
    output logic [WIDTH-1:0]       O_DATA,
    output logic                   O_VALID,
    input  logic                   O_READY,
    output logic [clog2(DEPTH):0]  COUNT,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   ALMOST_FULL
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_buffer: DEPTH must be a power of two and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("fifo_buffer: AF_LEVEL must lie in 1..DEPTH");
    end

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    // Flags come from the registered count only, so no I_* to O_* path exists.
    always_comb begin
        FULL        = (count_q == DepthCnt);
        EMPTY       = (count_q == '0);
        ALMOST_FULL = (count_q >= AfCnt);
        I_READY     = !FULL;
        O_VALID     = !EMPTY;
        COUNT       = count_q;
    end

    assign push = I_VALID & I_READY;
    assign pop  = O_VALID & O_READY;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    buffer_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PtrW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (I_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (O_DATA)
    );

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed vector table plus hand sequences on a 8x4 FIFO, and a random scoreboard run on 16x8.
module tb_fifo_buffer;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] i_data;
    logic       i_valid, o_ready;
    logic [7:0] o_data;
    logic       i_ready, o_valid, full, empty, af;
    logic [2:0] count;

    logic [15:0] r_i_data;
    logic        r_i_valid, r_o_ready;
    logic [15:0] r_o_data;
    logic        r_i_ready, r_o_valid, r_full, r_empty, r_af;
    logic [3:0]  r_count;

    int n_vec = 0;
    int n_err = 0;

    fifo_buffer #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .CLK(clk), .RST(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready),
        .O_DATA(o_data), .O_VALID(o_valid), .O_READY(o_ready), .COUNT(count),
        .FULL(full), .EMPTY(empty), .ALMOST_FULL(af)
    );

    fifo_buffer #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) dut_r (
        .CLK(clk), .RST(rst), .I_DATA(r_i_data), .I_VALID(r_i_valid), .I_READY(r_i_ready),
        .O_DATA(r_o_data), .O_VALID(r_o_valid), .O_READY(r_o_ready), .COUNT(r_count),
        .FULL(r_full), .EMPTY(r_empty), .ALMOST_FULL(r_af)
    );

    always #5 clk = ~clk;

    // Inputs, then state expected after the edge; flags = {full, empty, af, o_valid, i_ready}.
    typedef struct packed {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic [2:0] cnt;
        logic [4:0] flags;
        logic [7:0] od;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags_now();
        return {full, empty, af, o_valid, i_ready};
    endfunction

    logic [15:0] sb [$];
    int          n_model;
    logic        do_push, do_pop;

    initial begin
        vecs[0]  = {1'b1, 8'hA1, 1'b0, 3'd1, 5'b00011, 8'hA1};
        vecs[1]  = {1'b1, 8'hB2, 1'b0, 3'd2, 5'b00011, 8'hA1};
        vecs[2]  = {1'b1, 8'hC3, 1'b0, 3'd3, 5'b00111, 8'hA1};
        vecs[3]  = {1'b1, 8'hD4, 1'b0, 3'd4, 5'b10110, 8'hA1};
        vecs[4]  = {1'b1, 8'hEE, 1'b0, 3'd4, 5'b10110, 8'hA1};
        vecs[5]  = {1'b0, 8'h00, 1'b1, 3'd3, 5'b00111, 8'hB2};
        vecs[6]  = {1'b0, 8'h00, 1'b1, 3'd2, 5'b00011, 8'hC3};
        vecs[7]  = {1'b0, 8'h00, 1'b1, 3'd1, 5'b00011, 8'hD4};
        vecs[8]  = {1'b0, 8'h00, 1'b1, 3'd0, 5'b01001, 8'h00};
        vecs[9]  = {1'b1, 8'h11, 1'b0, 3'd1, 5'b00011, 8'h11};
        vecs[10] = {1'b1, 8'h22, 1'b0, 3'd2, 5'b00011, 8'h11};
        vecs[11] = {1'b1, 8'h33, 1'b1, 3'd2, 5'b00011, 8'h22};
        vecs[12] = {1'b1, 8'h44, 1'b1, 3'd2, 5'b00011, 8'h33};
        vecs[13] = {1'b1, 8'h55, 1'b0, 3'd3, 5'b00111, 8'h33};
        vecs[14] = {1'b1, 8'h66, 1'b0, 3'd4, 5'b10110, 8'h33};
        vecs[15] = {1'b1, 8'h77, 1'b1, 3'd3, 5'b00111, 8'h44};
        vecs[16] = {1'b1, 8'h77, 1'b0, 3'd4, 5'b10110, 8'h44};
        vecs[17] = {1'b0, 8'h00, 1'b1, 3'd3, 5'b00111, 8'h55};
        vecs[18] = {1'b0, 8'h00, 1'b1, 3'd2, 5'b00011, 8'h66};
        vecs[19] = {1'b0, 8'h00, 1'b1, 3'd1, 5'b00011, 8'h77};
        vecs[20] = {1'b0, 8'h00, 1'b1, 3'd0, 5'b01001, 8'h00};
        vecs[21] = {1'b1, 8'h5A, 1'b1, 3'd1, 5'b00011, 8'h5A};
        vecs[22] = {1'b0, 8'h00, 1'b1, 3'd0, 5'b01001, 8'h00};

        i_data = '0; i_valid = 1'b0; o_ready = 1'b0;
        r_i_data = '0; r_i_valid = 1'b0; r_o_ready = 1'b0;
        rst = 1'b1;
        #12;
        check("reset_count", 32'(count), 32'd0);
        check("reset_flags", 32'(flags_now()), 32'(5'b01001));
        rst = 1'b0;
        step();
        step();
        check("idle_count", 32'(count), 32'd0);
        check("idle_flags", 32'(flags_now()), 32'(5'b01001));

        // Latency: pushed word visible only after the push edge.
        i_data = 8'h5A; i_valid = 1'b1;
        #1;
        check("lat_ovalid_before", 32'(o_valid), 32'd0);
        step();
        i_valid = 1'b0;
        check("lat_ovalid_after", 32'(o_valid), 32'd1);
        check("lat_data_after", 32'(o_data), 32'h5A);
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        check("lat_drained", 32'(empty), 32'd1);

        for (int i = 0; i < 23; i++) begin
            i_valid = vecs[i].iv;
            i_data  = vecs[i].id;
            o_ready = vecs[i].ordy;
            step();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(vecs[i].flags));
            if (vecs[i].flags[1]) begin
                check($sformatf("vec%0d_data", i), 32'(o_data), 32'(vecs[i].od));
            end
        end

        // Asynchronous reset with three words held.
        i_valid = 1'b1; o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'h70 + i);
            step();
        end
        i_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_flags", 32'(flags_now()), 32'(5'b01001));
        #1;
        rst = 1'b0;
        step();
        check("post_rst_count", 32'(count), 32'd0);

        // Random traffic against a queue scoreboard.
        n_model = 0;
        for (int c = 0; c < 1000; c++) begin
            check("rnd_count", 32'(r_count), 32'(n_model));
            check("rnd_flags", 32'({r_full, r_empty, r_af, r_o_valid, r_i_ready}),
                  32'({n_model == 8, n_model == 0, n_model >= 6, n_model != 0, n_model != 8}));
            r_i_valid = 1'($urandom_range(0, 1));
            r_o_ready = ($urandom_range(0, 2) != 0);
            r_i_data  = 16'($urandom);
            do_push   = r_i_valid && (n_model < 8);
            do_pop    = r_o_ready && (n_model > 0);
            if (do_pop) begin
                check("rnd_data", 32'(r_o_data), 32'(sb[0]));
            end
            step();
            if (do_pop) begin
                void'(sb.pop_front());
                n_model--;
            end
            if (do_push) begin
                sb.push_back(r_i_data);
                n_model++;
            end
        end
        r_i_valid = 1'b0; r_o_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
